video_timing_gen: RTL and testbench

Raster timing master that produces the pixel coordinate stream (px, py, de) consumed by the mode pixel generators, plus HDMI-side sync. Counts a 1280x720p60 raster by default and latches the requested display mode at frame start so mode changes never tear mid-frame. Also emits sync/de copies delayed to line up with the generators' registered RGB output.

---
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_timing_gen.sv | 126 ++++++++++++
 tb/tb_video_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bus between video_timing_gen and the pixel generators.
// Optional frame_cnt member exists only when VTG_FRAME_COUNT_EN is defined.
interface video_timing_gen_if;
  logic        en;
  logic [2:0]  mode_req;
  logic [11:0] px;
  logic [11:0] py;
  logic        de;
  logic [2:0]  mode;
  logic        frame_start;
  logic        hsync_d;
  logic        vsync_d;
  logic        de_d;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  en, mode_req,
    output px, py, de, mode, frame_start, hsync_d, vsync_d, de_d
`ifdef VTG_FRAME_COUNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output en, mode_req,
    input  px, py, de, mode, frame_start, hsync_d, vsync_d, de_d
`ifdef VTG_FRAME_COUNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing master (px/py/de, frame-latched mode, delayed syncs).
// Optional VTG_FRAME_COUNT_EN adds a 16-bit frame counter output.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1,
  parameter int PIPE_DLY = 2
) (
  input logic               clk,
  input logic               rst_n,
  video_timing_gen_if.master vtg
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic POL_INV = (SYNC_POL == 0);

  logic [11:0] px_q, px_d, py_q, py_d;
  logic        run_q, run_d;
  logic        active_q, active_d;
  logic        fs_q, fs_d;
  logic [2:0]  mode_q, mode_d;
  logic        hs, vs;

  // run_q marks that the raster is live; its rising edge forces a fresh frame at (0,0).
  always_comb begin
    px_d  = px_q;
    py_d  = py_q;
    run_d = run_q;
    fs_d  = 1'b0;
    if (!vtg.en) begin
      px_d  = '0;
      py_d  = '0;
      run_d = 1'b0;
    end else if (!run_q) begin
      px_d  = '0;
      py_d  = '0;
      run_d = 1'b1;
      fs_d  = 1'b1;
    end else begin
      if (px_q == 12'(H_TOTAL - 1)) begin
        px_d = '0;
        py_d = (py_q == 12'(V_TOTAL - 1)) ? 12'd0 : py_q + 12'd1;
      end else begin
        px_d = px_q + 12'd1;
      end
      fs_d = (px_d == 12'd0) && (py_d == 12'd0);
    end
    active_d = run_d && (px_d < 12'(H_ACTIVE)) && (py_d < 12'(V_ACTIVE));
    mode_d   = fs_d ? vtg.mode_req : mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q     <= '0;
      py_q     <= '0;
      run_q    <= 1'b0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      mode_q   <= '0;
    end else begin
      px_q     <= px_d;
      py_q     <= py_d;
      run_q    <= run_d;
      active_q <= active_d;
      fs_q     <= fs_d;
      mode_q   <= mode_d;
    end
  end

  // Syncs decode from the registered counters, so they share px/py timing.
  assign hs = ((px_q >= 12'(HS_START)) && (px_q < 12'(HS_END))) ^ POL_INV;
  assign vs = ((py_q >= 12'(VS_START)) && (py_q < 12'(VS_END))) ^ POL_INV;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign vtg.hsync_d = hs;
      assign vtg.vsync_d = vs;
      assign vtg.de_d    = active_q;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= {POL_INV, POL_INV, 1'b0};
        end else begin
          dly_q[0] <= {hs, vs, active_q};
          for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign vtg.hsync_d = dly_q[PIPE_DLY-1][2];
      assign vtg.vsync_d = dly_q[PIPE_DLY-1][1];
      assign vtg.de_d    = dly_q[PIPE_DLY-1][0];
    end
  endgenerate

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] fcnt_q;
  logic        seen_q;
  // The first frame_start only arms the counter so it reads N-1 after N frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      seen_q <= 1'b0;
    end else if (fs_d) begin
      if (seen_q) fcnt_q <= fcnt_q + 16'd1;
      seen_q <= 1'b1;
    end
  end
  assign vtg.frame_cnt = fcnt_q;
`endif

  assign vtg.px          = px_q;
  assign vtg.py          = py_q;
  assign vtg.de          = active_q;
  assign vtg.mode        = mode_q;
  assign vtg.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed checks of video_timing_gen on a 16x8 raster.
// Two instances: active-high syncs with 2-clock delay, and active-low syncs undelayed.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_r = 1'b1;
  logic [2:0] mode_r = 3'd0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing_gen_if if0 ();
  video_timing_gen_if if1 ();
  assign if0.en = en_r;
  assign if1.en = en_r;
  assign if0.mode_req = mode_r;
  assign if1.mode_req = mode_r;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .PIPE_DLY(2)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .vtg(if0.master));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .PIPE_DLY(0)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .vtg(if1.master));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference raster state, H_TOTAL=16, V_TOTAL=8, hsync px 10..12, vsync py 5..6.
  int m_px = 0, m_py = 0;
  bit m_run = 0, m_fs = 0, m_de = 0, m_seen = 0;
  logic [2:0] m_mode = 3'd0;
  int m_fcnt = 0;
  logic [2:0] h1 = 3'b000, h2 = 3'b000;

  task automatic step();
    logic [2:0] cur, exp_d;
    bit hs, vs;
    @(posedge clk);
    @(negedge clk);
    if (!en_r) begin
      m_px = 0; m_py = 0; m_run = 0; m_fs = 0;
    end else if (!m_run) begin
      m_px = 0; m_py = 0; m_run = 1; m_fs = 1;
    end else begin
      if (m_px == 15) begin
        m_px = 0;
        m_py = (m_py == 7) ? 0 : m_py + 1;
      end else begin
        m_px = m_px + 1;
      end
      m_fs = (m_px == 0) && (m_py == 0);
    end
    m_de = m_run && (m_px < 8) && (m_py < 4);
    if (m_fs) begin
      m_mode = mode_r;
      if (m_seen) m_fcnt = m_fcnt + 1;
      m_seen = 1;
    end
    hs = (m_px >= 10) && (m_px < 13);
    vs = (m_py >= 5) && (m_py < 7);
    cur = {hs, vs, m_de};
    exp_d = h2;
    h2 = h1;
    h1 = cur;
    check("px", if0.px, m_px);
    check("py", if0.py, m_py);
    check("de", if0.de, m_de);
    check("frame_start", if0.frame_start, m_fs);
    check("mode", if0.mode, m_mode);
    check("hsync_d", if0.hsync_d, exp_d[2]);
    check("vsync_d", if0.vsync_d, exp_d[1]);
    check("de_d", if0.de_d, exp_d[0]);
    check("n_hsync_d", if1.hsync_d, !hs);
    check("n_vsync_d", if1.vsync_d, !vs);
    check("n_de_d", if1.de_d, m_de);
`ifdef VTG_FRAME_COUNT_EN
    check("frame_cnt", if0.frame_cnt, m_fcnt);
`endif
  endtask

  initial begin
    int de_cnt;
    de_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_px", if0.px, 0);
    check("rst_py", if0.py, 0);
    check("rst_de", if0.de, 0);
    check("rst_mode", if0.mode, 0);
    check("rst_fs", if0.frame_start, 0);
    check("rst_hsync_d", if0.hsync_d, 0);
    check("rst_vsync_d", if0.vsync_d, 0);
    check("rst_de_d", if0.de_d, 0);
    check("rst_n_hsync_d", if1.hsync_d, 1);
    check("rst_n_vsync_d", if1.vsync_d, 1);
    rst_n = 1'b1;

    for (int n = 0; n < 294; n++) begin
      step();
      if (n < 128) de_cnt += int'(if0.de);
      if (n == 0) begin
        check("first_px", if0.px, 0);
        check("first_de", if0.de, 1);
        check("first_fs", if0.frame_start, 1);
      end
      if (n == 15) check("line_end_px", if0.px, 15);
      if (n == 16) begin
        check("wrap_px", if0.px, 0);
        check("wrap_py", if0.py, 1);
      end
      if (n == 12) check("hs_rise", if0.hsync_d, 1);
      if (n == 15) check("hs_fall", if0.hsync_d, 0);
      if (n == 10) check("n_hs_fall", if1.hsync_d, 0);
      if (n == 82) check("vs_rise", if0.vsync_d, 1);
      if (n == 127) begin
        check("de_per_frame", de_cnt, 32);
        check("mode_hold", if0.mode, 0);
        check("last_py", if0.py, 7);
      end
      if (n == 128) begin
        check("fs_period", if0.frame_start, 1);
        check("mode_new", if0.mode, 4);
      end
      if (n == 48) mode_r = 3'd4;
    end

    en_r = 1'b0;
    mode_r = 3'd2;
    repeat (4) begin
      step();
      check("off_px", if0.px, 0);
      check("off_de", if0.de, 0);
      check("off_mode", if0.mode, 4);
    end
    en_r = 1'b1;
    step();
    check("reen_fs", if0.frame_start, 1);
    check("reen_px", if0.px, 0);
    check("reen_mode", if0.mode, 2);
`ifdef VTG_FRAME_COUNT_EN
    check("frame_cnt_4th", if0.frame_cnt, 3);
`endif
    repeat (20) step();
    check("reen_px_20", if0.px, 4);
    check("reen_py_20", if0.py, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
